// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state, lane constants and lane-select helper for the write-back serializer.
package wb_pkg;
  typedef enum logic {WB_IDLE, WB_SEND} wb_state_e;
  localparam int WB_LANES = 4;
  localparam int WB_LANE_STRIDE = 8;
  localparam int DWORD_BITS = 64;
  // Lowest set lane at or above from; returns WB_LANES when no lane remains.
  function automatic logic [2:0] lane_sel(input logic [3:0] mask, input logic [2:0] from);
    lane_sel = 3'(WB_LANES);
    for (int i = WB_LANES - 1; i >= 0; i--)
      if (mask[i] && 3'(i) >= from) lane_sel = 3'(i);
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO with flush; head entry is presented on dout.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d = flush ? '0 : wr_q + AW'(push);
    rd_d = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk)
    if (push && !flush) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
endmodule

// File: rtl/lsru_wb_serializer.sv
// lsru_wb_serializer: queues LSRU results and drains them one dword per cycle to the memory port.
// Define WB_LANE_MASK_EN to honour Mask_in; otherwise every entry writes all four lanes.
module lsru_wb_serializer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Valid_in,
  output logic                  Ready_out,
  input  logic                  Finish_in,
  input  logic [3:0]            Mask_in,
  input  logic [ADDR_BITS-1:0]  Base_addr_in,
  input  logic [DWORD_BITS-1:0] D0_in,
  input  logic [DWORD_BITS-1:0] D1_in,
  input  logic [DWORD_BITS-1:0] D2_in,
  input  logic [DWORD_BITS-1:0] D3_in,
  output logic                  Mem_we_out,
  input  logic                  Mem_ready_in,
  output logic [ADDR_BITS-1:0]  Mem_addr_out,
  output logic [DWORD_BITS-1:0] Mem_data_out,
  output logic [$clog2(DEPTH):0] Count_out,
  output logic                  Busy_out
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef WB_LANE_MASK_EN
  localparam int MW = 4;
`else
  localparam int MW = 0;
`endif
  localparam int W = MW + ADDR_BITS + WB_LANES * DWORD_BITS;
  wb_state_e state_q, state_d;
  logic [1:0] lane_q, lane_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d, head_base;
  logic [DWORD_BITS-1:0] data_q, data_d;
  logic [DWORD_BITS-1:0] lane_data [WB_LANES];
  logic we_q, we_d, busy_q, busy_d, rst_q;
  logic push, pop, full, empty;
  logic [3:0] head_mask;
  logic [2:0] sel;
  logic [W-1:0] din, head;
`ifdef WB_LANE_MASK_EN
  assign din = {Mask_in, Base_addr_in, D3_in, D2_in, D1_in, D0_in};
  assign head_mask = head[W-1 -: 4];
`else
  logic unused_mask;
  assign unused_mask = ^Mask_in;
  assign din = {Base_addr_in, D3_in, D2_in, D1_in, D0_in};
  assign head_mask = 4'hF;
`endif
  wb_fifo #(.DEPTH(DEPTH), .WIDTH(W)) u_fifo (
    .clk(CLK), .rst(RST), .push(push), .pop(pop), .flush(Finish_in),
    .din(din), .dout(head), .full(full), .empty(empty), .count(Count_out)
  );
  always_comb begin
    for (int i = 0; i < WB_LANES; i++) lane_data[i] = head[i*DWORD_BITS +: DWORD_BITS];
  end
  assign head_base = head[WB_LANES*DWORD_BITS +: ADDR_BITS];
  // Ready is held low for the cycle after reset so the pipeline never pushes into a resetting FIFO.
  assign Ready_out = !full && !rst_q;
  assign push = Valid_in && Ready_out && !Finish_in;
  // The head entry stays in place during SEND, so lanes are always read straight from it.
  always_comb begin
    sel = lane_sel(head_mask, state_q == WB_IDLE ? 3'd0 : 3'(lane_q) + 3'd1);
    state_d = state_q;
    lane_d = lane_q;
    addr_d = addr_q;
    data_d = data_q;
    we_d = we_q;
    pop = 1'b0;
    if (Finish_in) begin
      state_d = WB_IDLE;
      we_d = 1'b0;
    end else if (state_q == WB_IDLE ? !empty : Mem_ready_in) begin
      pop = sel[2];
      state_d = sel[2] ? WB_IDLE : WB_SEND;
      we_d = !sel[2];
      if (!sel[2]) begin
        lane_d = sel[1:0];
        addr_d = head_base + ADDR_BITS'(WB_LANE_STRIDE * int'(sel[1:0]));
        data_d = lane_data[sel[1:0]];
      end
    end
    busy_d = !Finish_in && (state_d == WB_SEND || (Count_out + CW'(push) - CW'(pop)) != '0);
  end
  always_ff @(posedge CLK) begin
    rst_q <= RST;
    if (RST) begin
      state_q <= WB_IDLE;
      lane_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      addr_q <= addr_d;
      data_q <= data_d;
      we_q <= we_d;
      busy_q <= busy_d;
    end
  end
  assign Mem_we_out = we_q;
  assign Mem_addr_out = addr_q;
  assign Mem_data_out = data_q;
  assign Busy_out = busy_q;
endmodule

// File: tb/tb_lsru_wb_serializer.sv
// tb_lsru_wb_serializer: scoreboard bench for lsru_wb_serializer with directed and random traffic.
module tb_lsru_wb_serializer;
  localparam int DEPTH = 4;
  localparam int AB = 16;
`ifdef WB_LANE_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif
  logic CLK = 1'b0, RST = 1'b1, Valid_in = 1'b0, Finish_in = 1'b0, Mem_ready_in = 1'b1;
  logic [3:0] Mask_in = '0;
  logic [AB-1:0] Base_addr_in = '0;
  logic [63:0] D0_in = '0, D1_in = '0, D2_in = '0, D3_in = '0;
  logic Ready_out, Mem_we_out, Busy_out;
  logic [AB-1:0] Mem_addr_out;
  logic [63:0] Mem_data_out;
  logic [$clog2(DEPTH):0] Count_out;

  lsru_wb_serializer #(.DEPTH(DEPTH), .ADDR_BITS(AB)) dut (
    .CLK(CLK), .RST(RST), .Valid_in(Valid_in), .Ready_out(Ready_out), .Finish_in(Finish_in),
    .Mask_in(Mask_in), .Base_addr_in(Base_addr_in), .D0_in(D0_in), .D1_in(D1_in), .D2_in(D2_in),
    .D3_in(D3_in), .Mem_we_out(Mem_we_out), .Mem_ready_in(Mem_ready_in), .Mem_addr_out(Mem_addr_out),
    .Mem_data_out(Mem_data_out), .Count_out(Count_out), .Busy_out(Busy_out)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {logic [AB-1:0] a; logic [63:0] d;} wr_t;
  wr_t exp_q[$];
  int n_chk = 0, n_pass = 0, n_wr = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  // Reference model: an accepted entry expands into its writes, ascending lane order.
  task automatic model_push();
    logic [63:0] d [4];
    d = '{D0_in, D1_in, D2_in, D3_in};
    for (int i = 0; i < 4; i++)
      if (!MASK_EN || Mask_in[i]) exp_q.push_back('{a: Base_addr_in + AB'(8 * i), d: d[i]});
  endtask

  // Monitor: samples on the falling edge what the next rising edge will commit.
  initial begin
    logic stall_p;
    logic [AB-1:0] a_p;
    logic [63:0] d_p;
    wr_t e;
    stall_p = 1'b0;
    forever begin
      @(negedge CLK);
      if (stall_p && !RST) begin
        chk("hold_we", Mem_we_out, 1);
        chk("hold_addr", Mem_addr_out, a_p);
        chk("hold_data", Mem_data_out, d_p);
      end
      if (RST) exp_q.delete();
      else begin
        if (Mem_we_out && Mem_ready_in) begin
          n_wr++;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", Mem_addr_out, Mem_data_out);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", Mem_addr_out, e.a);
            chk("wr_data", Mem_data_out, e.d);
          end
        end
        if (Finish_in) exp_q.delete();
        else if (Valid_in && Ready_out) model_push();
      end
      stall_p = Mem_we_out && !Mem_ready_in && !Finish_in && !RST;
      a_p = Mem_addr_out;
      d_p = Mem_data_out;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_in(input logic [3:0] m, input logic [AB-1:0] b);
    Valid_in = 1'b1;
    Mask_in = m;
    Base_addr_in = b;
    D0_in = {$urandom, $urandom};
    D1_in = {$urandom, $urandom};
    D2_in = {$urandom, $urandom};
    D3_in = {$urandom, $urandom};
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && Busy_out; k++) cyc();
    chk("drain_busy", Busy_out, 0);
    chk("drain_sb_empty", exp_q.size(), 0);
  endtask

  task automatic run_single();
    Mem_ready_in = 1'b1;
    set_in(4'hF, 16'h0100);
    D0_in = 64'h1111_1111_1111_1111;
    D1_in = 64'h2222_2222_2222_2222;
    D2_in = 64'h3333_3333_3333_3333;
    D3_in = 64'h4444_4444_4444_4444;
    chk("single_ready", Ready_out, 1);
    cyc();
    Valid_in = 1'b0;
    chk("single_count_t1", Count_out, 1);
    chk("single_we_t1", Mem_we_out, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("single_we", Mem_we_out, 1);
      chk("single_addr", Mem_addr_out, 64'h0100 + 64'(8 * i));
    end
    cyc();
    chk("single_busy_t6", Busy_out, 0);
    chk("single_we_t6", Mem_we_out, 0);
  endtask

  initial begin
    int w0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_we", Mem_we_out, 0);
    chk("rst_addr", Mem_addr_out, 0);
    chk("rst_data", Mem_data_out, 0);
    chk("rst_count", Count_out, 0);
    chk("rst_busy", Busy_out, 0);
    chk("rst_ready", Ready_out, 0);
    RST = 1'b0;
    chk("rst_ready_after", Ready_out, 0);
    cyc();
    chk("ready_up", Ready_out, 1);

    run_single();

    Mem_ready_in = 1'b0;
    set_in(4'b1010, 16'h0200);
    cyc();
    Valid_in = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk("bp_we", Mem_we_out, 1);
      chk("bp_addr_hold", Mem_addr_out, MASK_EN ? 64'h0208 : 64'h0200);
      cyc();
    end
    Mem_ready_in = 1'b1;
    chk("bp_addr_last", Mem_addr_out, MASK_EN ? 64'h0208 : 64'h0200);
    cyc();
    chk("bp_addr_next", Mem_addr_out, MASK_EN ? 64'h0218 : 64'h0208);
    wait_idle(50);

    Mem_ready_in = 1'b0;
    w0 = n_wr;
    for (int k = 0; k < 4; k++) begin
      set_in(4'hF, AB'($urandom));
      chk("fill_ready", Ready_out, 1);
      cyc();
    end
    set_in(4'hF, AB'($urandom));
    for (int k = 0; k < 3; k++) begin
      chk("full_ready", Ready_out, 0);
      chk("full_count", Count_out, 4);
      cyc();
    end
    Mem_ready_in = 1'b1;
    for (int k = 0; k < 50 && !Ready_out; k++) cyc();
    chk("fifth_accept", Ready_out, 1);
    cyc();
    Valid_in = 1'b0;
    wait_idle(200);
    chk("full_writes", n_wr - w0, 20);

    w0 = n_wr;
    set_in(4'b0011, 16'hFFF8);
    cyc();
    set_in(4'b0000, 16'h0300);
    cyc();
    Valid_in = 1'b0;
    chk("wrap_addr0", Mem_addr_out, 64'hFFF8);
    cyc();
    chk("wrap_addr1", Mem_addr_out, 64'h0000);
    wait_idle(50);
    chk("wrap_writes", n_wr - w0, MASK_EN ? 2 : 8);

    Mem_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(4'hF, AB'($urandom));
      cyc();
    end
    Valid_in = 1'b0;
    for (int k = 0; k < 20 && !Mem_we_out; k++) cyc();
    chk("flush_pre_we", Mem_we_out, 1);
    chk("flush_pre_count", Count_out, 3);
    set_in(4'hF, AB'($urandom));
    Finish_in = 1'b1;
    Mem_ready_in = 1'b1;
    cyc();
    Finish_in = 1'b0;
    Valid_in = 1'b0;
    chk("flush_we", Mem_we_out, 0);
    chk("flush_count", Count_out, 0);
    chk("flush_busy", Busy_out, 0);
    w0 = n_wr;
    repeat (10) cyc();
    chk("flush_no_writes", n_wr - w0, 0);

    set_in(4'hF, 16'h0400);
    cyc();
    Valid_in = 1'b0;
    for (int k = 0; k < 20 && !Mem_we_out; k++) cyc();
    cyc();
    Mem_ready_in = 1'b0;
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("mrst_we", Mem_we_out, 0);
    chk("mrst_addr", Mem_addr_out, 0);
    chk("mrst_data", Mem_data_out, 0);
    chk("mrst_count", Count_out, 0);
    chk("mrst_busy", Busy_out, 0);
    chk("mrst_ready", Ready_out, 0);
    cyc();
    chk("mrst_ready_up", Ready_out, 1);
    run_single();

    for (int k = 0; k < 400; k++) begin
      set_in(4'($urandom), AB'($urandom));
      Valid_in = 1'($urandom);
      Mem_ready_in = ($urandom % 10) < 7;
      Finish_in = ($urandom % 50) == 0;
      cyc();
    end
    Valid_in = 1'b0;
    Finish_in = 1'b0;
    Mem_ready_in = 1'b1;
    cyc();
    wait_idle(500);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
